// File: rtl/if_fetch_ctrl.sv
// OpenMIPS IF-stage fetch controller: owns the PC, reads the instruction ROM
// over a ce/ack handshake and hands instructions to ID through a one-entry
// valid/ready register. Optional `PC_OVF_EN adds a sticky PC-wrap halt.
module if_fetch_ctrl #(
  parameter int ADDR_W = 6,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [INST_W-1:0] rom_data,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              id_ready,
  output logic              pc_ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
`ifdef PC_OVF_EN
  localparam logic [1:0]        HALT    = 2'd2;
  localparam logic [ADDR_W-1:0] PC_LAST = '1;
`endif

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              slot_free;
  logic              xfer;

  // A ROM response is only taken when the output entry is empty or leaving;
  // otherwise the ROM keeps holding it because rom_addr does not move.
  assign rom_ce    = (state == REQ);
  assign rom_addr  = pc;
  assign slot_free = !if_valid || id_ready;
  assign xfer      = rom_ce && rom_ack && slot_free;

`ifdef PC_OVF_EN
  logic ovf_q;
  assign pc_ovf = ovf_q;
`else
  assign pc_ovf = 1'b0;
`endif

  // A branch wins over a same-cycle transfer, so the wrong-path word is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
`ifdef PC_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else if (branch_flag) begin
      pc       <= branch_addr;
      if_valid <= 1'b0;
      state    <= REQ;
`ifdef PC_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end
        REQ: begin
          if (xfer) begin
            if_inst  <= rom_data;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + ADDR_W'(1);
`ifdef PC_OVF_EN
            if (pc == PC_LAST) begin
              ovf_q <= 1'b1;
              state <= HALT;
            end
`endif
          end else if (if_valid && id_ready) begin
            if_valid <= 1'b0;
          end
        end
`ifdef PC_OVF_EN
        HALT: begin
          if (if_valid && id_ready) begin
            if_valid <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: the stimulus side predicts the in-order
// instruction stream, a monitor pops it as ID consumes entries.
module tb_if_fetch_ctrl;
  localparam int AW = 6;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_ce;
  logic [AW-1:0] rom_addr;
  logic          rom_ack;
  logic [IW-1:0] rom_data;
  logic          branch_flag;
  logic [AW-1:0] branch_addr;
  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic [IW-1:0] if_inst;
  logic          id_ready;
  logic          pc_ovf;

  int total = 0;
  int bad   = 0;

  // Expected program-order stream of addresses still to be presented to ID.
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] tail = '0;
  logic [AW-1:0] last_addr = '0;
  logic          mdl_ce = 1'b0;
  logic          mdl_halt = 1'b0;
  logic          prev_valid = 1'b0;

  if_fetch_ctrl #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .branch_flag(branch_flag),
    .branch_addr(branch_addr), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .id_ready(id_ready), .pc_ovf(pc_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    return 32'hC0DE_0000 ^ (x * 32'h0100_0193) ^ (x << 8);
  endfunction

  assign rom_data = inst_of(rom_addr);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(tail);
      tail = tail + AW'(1);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, update the predicted
  // stream, then return just after the following rising edge.
  task automatic applyStimulus(input logic r, input logic br, input logic [AW-1:0] ba,
                               input logic rdy, input logic rnd_ack, input logic ack_val);
    @(negedge clk);
    rst         = r;
    branch_flag = br;
    branch_addr = ba;
    id_ready    = rdy;
    if (rnd_ack) begin
      if (!(rom_ce && rom_ack && rom_addr == last_addr))
        rom_ack = ($urandom_range(0, 3) != 0);
    end else begin
      rom_ack = ack_val;
    end
    last_addr = rom_addr;
    if (r) begin
      exp_q.delete();
      tail = '0;
    end else if (br) begin
      exp_q.delete();
      tail = ba;
    end
    refill();
    @(posedge clk);
    #2;
  endtask

  task automatic expectPc(input string name, input logic [AW-1:0] a);
    checkOutput({name, "_valid"}, 32'(if_valid), 32'd1);
    checkOutput({name, "_pc"}, 32'(if_pc), 32'(a));
    checkOutput({name, "_inst"}, if_inst, inst_of(a));
  endtask

  // Monitor: one step per rising edge, judged from the spec's transfer rules.
  task automatic monitorStep();
    logic exp_valid;
    logic xfer_m;
    exp_valid = 1'b0;
    if (rst) begin
      mdl_ce   = 1'b0;
      mdl_halt = 1'b0;
      checkOutput("mon_rst_valid", 32'(if_valid), 32'd0);
      checkOutput("mon_rst_pc", 32'(if_pc), 32'd0);
      checkOutput("mon_rst_inst", if_inst, 32'd0);
    end else if (branch_flag) begin
      mdl_ce   = 1'b1;
      mdl_halt = 1'b0;
      checkOutput("mon_br_valid", 32'(if_valid), 32'd0);
    end else begin
      xfer_m = mdl_ce && rom_ack && (!prev_valid || id_ready);
      if (prev_valid && id_ready) void'(exp_q.pop_front());
      if (xfer_m || (prev_valid && !id_ready)) begin
        exp_valid = 1'b1;
        checkOutput("mon_valid", 32'(if_valid), 32'd1);
        checkOutput("mon_pc", 32'(if_pc), 32'(exp_q[0]));
        checkOutput("mon_inst", if_inst, inst_of(exp_q[0]));
      end else begin
        checkOutput("mon_valid", 32'(if_valid), 32'd0);
      end
`ifdef PC_OVF_EN
      if (xfer_m && exp_q[0] == '1) mdl_halt = 1'b1;
`endif
      mdl_ce = !mdl_halt;
    end
    prev_valid = exp_valid;
    checkOutput("mon_ce", 32'(rom_ce), 32'(mdl_ce));
    checkOutput("mon_ovf", 32'(pc_ovf), 32'(mdl_halt));
    if (mdl_ce)
      checkOutput("mon_addr", 32'(rom_addr), exp_valid ? 32'(exp_q[1]) : 32'(exp_q[0]));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      monitorStep();
    end
  end

  initial begin
    rst = 1'b1; branch_flag = 1'b0; branch_addr = '0; id_ready = 1'b0; rom_ack = 1'b0;
    refill();

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_ce", 32'(rom_ce), 32'd0);
      checkOutput("rst_valid", 32'(if_valid), 32'd0);
      checkOutput("rst_ovf", 32'(pc_ovf), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("rel_ce", 32'(rom_ce), 32'd1);
    checkOutput("rel_addr", 32'(rom_addr), 32'd0);
    checkOutput("rel_valid", 32'(if_valid), 32'd0);

    // Zero-wait streaming.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      expectPc("stream", AW'(i));
    end

    // ID stall while address 3 is presented.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      expectPc("stall", AW'(3));
      checkOutput("stall_addr", 32'(rom_addr), 32'd4);
      checkOutput("stall_ce", 32'(rom_ce), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    expectPc("unstall", AW'(4));

    // Branch in the same cycle as the transfer of address 5.
    applyStimulus(1'b0, 1'b1, AW'(6'h20), 1'b1, 1'b0, 1'b1);
    checkOutput("br_valid", 32'(if_valid), 32'd0);
    checkOutput("br_addr", 32'(rom_addr), 32'h20);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    expectPc("br_target", AW'(6'h20));

    // Run across the top of the address space.
    applyStimulus(1'b0, 1'b1, AW'(6'h3E), 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    expectPc("top0", AW'(6'h3E));
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    expectPc("top1", AW'(6'h3F));
`ifdef PC_OVF_EN
    checkOutput("halt_ce", 32'(rom_ce), 32'd0);
    checkOutput("halt_ovf", 32'(pc_ovf), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("halt_drain", 32'(if_valid), 32'd0);
    checkOutput("halt_ce2", 32'(rom_ce), 32'd0);
    applyStimulus(1'b0, 1'b1, AW'(6'h10), 1'b1, 1'b0, 1'b1);
    checkOutput("unhalt_ovf", 32'(pc_ovf), 32'd0);
    checkOutput("unhalt_ce", 32'(rom_ce), 32'd1);
    checkOutput("unhalt_addr", 32'(rom_addr), 32'h10);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    expectPc("unhalt_pc", AW'(6'h10));
`else
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    expectPc("wrap0", AW'(0));
    checkOutput("wrap_ovf", 32'(pc_ovf), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    expectPc("wrap1", AW'(1));
`endif

    // Reset while a fetch is outstanding and the output holds an entry.
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_valid", 32'(if_valid), 32'd1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst_ce", 32'(rom_ce), 32'd0);
    checkOutput("mid_rst_valid", 32'(if_valid), 32'd0);
    checkOutput("mid_rst_pc", 32'(if_pc), 32'd0);
    checkOutput("mid_rst_inst", if_inst, 32'd0);
    checkOutput("mid_rst_ovf", 32'(pc_ovf), 32'd0);
    checkOutput("mid_rst_addr", 32'(rom_addr), 32'd0);

    // Randomized traffic: sticky ROM acks, ID back-pressure, branches, resets.
    for (int i = 0; i < 3000; i++) begin
      logic          r;
      logic          br;
      logic [AW-1:0] ba;
      logic          rdy;
      r   = ($urandom_range(0, 299) == 0);
      br  = ($urandom_range(0, 15) == 0);
      ba  = ($urandom_range(0, 3) == 0) ? AW'(60 + $urandom_range(0, 3))
                                        : AW'($urandom_range(0, 63));
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(r, br, ba, rdy, 1'b1, 1'b0);
    end

    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
